// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: core has fixed priority, debug gets a grant after MAX_BURST
// contested core grants. Optional debug lock behind `DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_stall,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                  dbg_lock,
`endif
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_e;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [3:0] burst_q, burst_d;
    owner_e     owner_q, owner_d;
    logic       at_max;
    logic       lock_eff;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_q, lock_d;
    // The lock only holds while dbg_lock stays high; the release cycle arbitrates normally.
    assign lock_eff = lock_q & dbg_lock;
    assign lock_d   = lock_q ? dbg_lock : (dbg_gnt & dbg_lock);
`else
    assign lock_eff = 1'b0;
`endif

    assign at_max = (burst_q >= BURST_MAX);

    always_comb begin
        core_gnt   = rst & core_req & ~lock_eff & (~dbg_req | ~at_max);
        dbg_gnt    = rst & dbg_req & ~core_gnt;
        core_stall = rst & core_req & ~core_gnt;

        mem_wen   = (core_gnt & core_we) | (dbg_gnt & dbg_we);
        mem_ren   = (core_gnt & ~core_we) | (dbg_gnt & ~dbg_we);
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end

        // Count only contested core grants; saturate at the bound.
        burst_d = burst_q;
        if (!dbg_req || dbg_gnt) begin
            burst_d = '0;
        end else if (core_gnt && !at_max) begin
            burst_d = burst_q + 4'd1;
        end

        owner_d = OWN_NONE;
        if (core_gnt && !core_we) begin
            owner_d = OWN_CORE;
        end else if (dbg_gnt && !dbg_we) begin
            owner_d = OWN_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            burst_q <= '0;
            owner_q <= OWN_NONE;
`ifdef DMEM_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            burst_q <= burst_d;
            owner_q <= owner_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign core_rvalid = rst & (owner_q == OWN_CORE);
    assign dbg_rvalid  = rst & (owner_q == OWN_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata   = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver queues per-cycle expectations,
// a negedge monitor pops and compares. Lock cases run when DMEM_ARB_LOCK_EN is set.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic        dbg_lock = 1'b0;
`endif

    logic [31:0] ram [256];

    typedef struct {
        int          id;
        logic        cg, dg, st, wen, ren;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        crv;
        logic [31:0] crd;
        logic        drv;
        logic [31:0] drd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    localparam logic [31:0] D10 = 32'hDEADBEEF;
    localparam logic [31:0] D01 = 32'h11111111;
    localparam logic [31:0] D02 = 32'h22222222;
    localparam logic [31:0] D20 = 32'h12345678;
    localparam logic [31:0] D30 = 32'hA5A5A5A5;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural RAM: synchronous write, 1-cycle registered read.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = D10;
        ram[8'h01] = D01;
        ram[8'h02] = D02;
        mem_rdata  = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", nm, id, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("core_gnt",    e.id, {31'h0, core_gnt},    {31'h0, e.cg});
            chk("dbg_gnt",     e.id, {31'h0, dbg_gnt},     {31'h0, e.dg});
            chk("core_stall",  e.id, {31'h0, core_stall},  {31'h0, e.st});
            chk("mem_wen",     e.id, {31'h0, mem_wen},     {31'h0, e.wen});
            chk("mem_ren",     e.id, {31'h0, mem_ren},     {31'h0, e.ren});
            chk("mem_addr",    e.id, {24'h0, mem_addr},    {24'h0, e.addr});
            chk("mem_wdata",   e.id, mem_wdata,            e.wd);
            chk("core_rvalid", e.id, {31'h0, core_rvalid}, {31'h0, e.crv});
            chk("core_rdata",  e.id, core_rdata,           e.crv ? e.crd : 32'h0);
            chk("dbg_rvalid",  e.id, {31'h0, dbg_rvalid},  {31'h0, e.drv});
            chk("dbg_rdata",   e.id, dbg_rdata,            e.drv ? e.drd : 32'h0);
        end
    end

    // Drive one cycle of stimulus and queue the hand-derived expectation for it.
    task automatic step(input logic r,
                        input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd,
                        input logic ecg, input logic edg,
                        input logic ecrv, input logic [31:0] ecrd,
                        input logic edrv, input logic [31:0] edrd);
        exp_t e;
        rst = r;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dbg_req  = dr; dbg_we  = dw; dbg_addr  = da; dbg_wdata  = dd;
        vec_id++;
        e.id   = vec_id;
        e.cg   = ecg;
        e.dg   = edg;
        e.st   = r & cr & ~ecg;
        e.wen  = (ecg & cw) | (edg & dw);
        e.ren  = (ecg & ~cw) | (edg & ~dw);
        e.addr = ecg ? ca : (edg ? da : 8'h00);
        e.wd   = ecg ? cd : (edg ? dd : 32'h0);
        e.crv  = ecrv; e.crd = ecrd;
        e.drv  = edrv; e.drd = edrd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req  = 0; dbg_we  = 0; dbg_addr  = 0; dbg_wdata  = 0;
        @(posedge clk);
        #1;

        // Reset held with both requesting: everything quiet.
        for (int i = 0; i < 3; i++)
            step(0, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 0,0, 0,0, 0,0);

        // Starvation bound: four core grants then one debug, twice.
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 0,0,   0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 1,D10, 0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 1,D10, 0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 1,D10, 0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 0,1, 1,D10, 0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 0,0,   1,D02);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 1,D10, 0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 1,D10, 0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 1,0, 1,D10, 0,0);
        step(1, 1,0,8'h10,32'h0, 1,0,8'h02,32'h0, 0,1, 1,D10, 0,0);

        // Debug write then core read of the same word.
        step(1, 0,0,8'h00,32'h0, 1,1,8'h20,D20,   0,1, 0,0,   1,D02);
        step(1, 1,0,8'h20,32'h0, 0,0,8'h00,32'h0, 1,0, 0,0,   0,0);
        step(1, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,0, 1,D20, 0,0);

        // Back-to-back reads from different requesters.
        step(1, 1,0,8'h01,32'h0, 0,0,8'h00,32'h0, 1,0, 0,0,   0,0);
        step(1, 0,0,8'h00,32'h0, 1,0,8'h02,32'h0, 0,1, 1,D01, 0,0);
        step(1, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,0, 0,0,   1,D02);

        // Core write, debug read back; debug wdata must still mux through on a read.
        step(1, 1,1,8'h30,D30,   0,0,8'h00,32'h0,          1,0, 0,0, 0,0);
        step(1, 0,0,8'h00,32'h0, 1,0,8'h30,32'h0BAD0BAD,   0,1, 0,0, 0,0);
        step(1, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0,          0,0, 0,0, 1,D30);

        // Reset mid-read drops the pending return.
        step(1, 1,0,8'h10,32'h0, 0,0,8'h00,32'h0, 1,0, 0,0, 0,0);
        step(0, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,0, 0,0, 0,0);
        step(1, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,0, 0,0, 0,0);

        // Debug dropping its request clears the burst count.
        for (int i = 0; i < 3; i++)
            step(1, 1,1,8'h40,32'h1, 1,1,8'h41,32'h2, 1,0, 0,0, 0,0);
        step(1, 1,1,8'h40,32'h1, 0,0,8'h00,32'h0, 1,0, 0,0, 0,0);
        for (int i = 0; i < 4; i++)
            step(1, 1,1,8'h40,32'h1, 1,1,8'h41,32'h2, 1,0, 0,0, 0,0);
        step(1, 1,1,8'h40,32'h1, 1,1,8'h41,32'h2, 0,1, 0,0, 0,0);

`ifdef DMEM_ARB_LOCK_EN
        dbg_lock = 1'b1;
        step(1, 0,0,8'h00,32'h0, 1,1,8'h50,32'h5, 0,1, 0,0, 0,0);
        for (int i = 0; i < 5; i++)
            step(1, 1,1,8'h40,32'h1, 1,1,8'h50,32'h5, 0,1, 0,0, 0,0);
        dbg_lock = 1'b0;
        step(1, 1,1,8'h40,32'h1, 1,1,8'h50,32'h5, 1,0, 0,0, 0,0);
`endif

        step(1, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,0, 0,0, 0,0);
        @(negedge clk);
        #1;
        chk("queue_drained", vec_id, exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
